// File: rtl/psram_ctrl.sv
// psram_ctrl: responder end of the arbiter->PSRAM request interface.
// Runs one single read, write or burst read at a time on a CellularRAM
// operated in asynchronous/page mode. The top level owns the DQ tristate.
//
// Ports
//   clk, reset       system clock, asynchronous active-high reset
//   mem_rd/mem_wr    level requests from the arbiter (read has priority)
//   mem_burst_op     with mem_rd: read BURST_LEN consecutive words
//   addr             23-bit word address
//   mem_wr_data      write data
//   mem_rd_data      read data, valid while mem_data_ok
//   mem_data_ok      one-cycle pulse per read word
//   mem_opp_begun    one-cycle pulse, request accepted and inputs latched
//   mem_ctrl_good    high exactly while idle after init (ready to accept)
//   mem_op_finish    one-cycle pulse, operation complete
//   ram_*            RAM pins; adv/clk/cre/ub/lb tied low for async 16-bit mode
module psram_ctrl #(
  parameter int unsigned T_INIT    = 7500,
  parameter int unsigned T_RD      = 4,
  parameter int unsigned T_PAGE    = 2,
  parameter int unsigned T_WR      = 4,
  parameter int unsigned T_REC     = 1,
  parameter int unsigned BURST_LEN = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic        mem_burst_op,
  input  logic [22:0] addr,
  input  logic [15:0] mem_wr_data,
  output logic [15:0] mem_rd_data,
  output logic        mem_data_ok,
  output logic        mem_opp_begun,
  output logic        mem_ctrl_good,
  output logic        mem_op_finish,
  output logic [22:0] ram_adr,
  input  logic [15:0] ram_dq_i,
  output logic [15:0] ram_dq_o,
  output logic        ram_dq_oe,
  output logic        ram_ce_n,
  output logic        ram_oe_n,
  output logic        ram_we_n,
  output logic        ram_adv_n,
  output logic        ram_clk,
  output logic        ram_cre,
  output logic        ram_ub_n,
  output logic        ram_lb_n
);

  localparam int unsigned ADR_W   = 23;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned WORDS_W = 5;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_REC
  } state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    init_cnt_q;
  logic [CNT_W-1:0]    tmr_q;
  logic [WORDS_W-1:0]  words_q;
  logic [ADR_W-1:0]    ram_adr_q;
  logic [DATA_W-1:0]   ram_dq_o_q;
  logic                ram_dq_oe_q;
  logic                ce_n_q;
  logic                oe_n_q;
  logic                we_n_q;
  logic [DATA_W-1:0]   rd_data_q;
  logic                data_ok_q;
  logic                begun_q;
  logic                good_q;
  logic                finish_q;

  logic [ADR_W-1:0]    next_adr_c;
  logic                page_cross_c;

  // Next burst address wraps mod 2^23; landing on a 16-word boundary costs a full random read.
  assign next_adr_c   = ram_adr_q + ADR_W'(1);
  assign page_cross_c = (next_adr_c[3:0] == 4'h0);

  // Controller FSM with all outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= '0;
      tmr_q       <= '0;
      words_q     <= '0;
      ram_adr_q   <= '0;
      ram_dq_o_q  <= '0;
      ram_dq_oe_q <= 1'b0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      rd_data_q   <= '0;
      data_ok_q   <= 1'b0;
      begun_q     <= 1'b0;
      good_q      <= 1'b0;
      finish_q    <= 1'b0;
    end else begin
      data_ok_q <= 1'b0;
      begun_q   <= 1'b0;
      finish_q  <= 1'b0;
      case (state_q)
        ST_INIT: begin
          if (init_cnt_q == CNT_W'(T_INIT - 1)) begin
            state_q <= ST_IDLE;
            good_q  <= 1'b1;
          end else begin
            init_cnt_q <= init_cnt_q + CNT_W'(1);
          end
        end
        ST_IDLE: begin
          if (mem_rd) begin
            state_q   <= ST_READ;
            good_q    <= 1'b0;
            begun_q   <= 1'b1;
            ram_adr_q <= addr;
            ce_n_q    <= 1'b0;
            oe_n_q    <= 1'b0;
            tmr_q     <= CNT_W'(T_RD - 1);
            words_q   <= mem_burst_op ? WORDS_W'(BURST_LEN - 1) : '0;
          end else if (mem_wr) begin
            state_q     <= ST_WRITE;
            good_q      <= 1'b0;
            begun_q     <= 1'b1;
            ram_adr_q   <= addr;
            ram_dq_o_q  <= mem_wr_data;
            ram_dq_oe_q <= 1'b1;
            ce_n_q      <= 1'b0;
            we_n_q      <= 1'b0;
            tmr_q       <= CNT_W'(T_WR - 1);
          end
        end
        ST_READ: begin
          if (tmr_q == '0) begin
            rd_data_q <= ram_dq_i;
            data_ok_q <= 1'b1;
            if (words_q != '0) begin
              // CE/OE stay low across words; only the address moves.
              words_q   <= words_q - WORDS_W'(1);
              ram_adr_q <= next_adr_c;
              tmr_q     <= page_cross_c ? CNT_W'(T_RD - 1) : CNT_W'(T_PAGE - 1);
            end else begin
              finish_q <= 1'b1;
              ce_n_q   <= 1'b1;
              oe_n_q   <= 1'b1;
              state_q  <= ST_REC;
              tmr_q    <= CNT_W'(T_REC - 1);
            end
          end else begin
            tmr_q <= tmr_q - CNT_W'(1);
          end
        end
        ST_WRITE: begin
          if (tmr_q == '0) begin
            ce_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            ram_dq_oe_q <= 1'b0;
            finish_q    <= 1'b1;
            state_q     <= ST_REC;
            tmr_q       <= CNT_W'(T_REC - 1);
          end else begin
            tmr_q <= tmr_q - CNT_W'(1);
          end
        end
        ST_REC: begin
          if (tmr_q == '0) begin
            state_q <= ST_IDLE;
            good_q  <= 1'b1;
          end else begin
            tmr_q <= tmr_q - CNT_W'(1);
          end
        end
        default: begin
          state_q <= ST_INIT;
        end
      endcase
    end
  end

  assign mem_rd_data   = rd_data_q;
  assign mem_data_ok   = data_ok_q;
  assign mem_opp_begun = begun_q;
  assign mem_ctrl_good = good_q;
  assign mem_op_finish = finish_q;
  assign ram_adr       = ram_adr_q;
  assign ram_dq_o      = ram_dq_o_q;
  assign ram_dq_oe     = ram_dq_oe_q;
  assign ram_ce_n      = ce_n_q;
  assign ram_oe_n      = oe_n_q;
  assign ram_we_n      = we_n_q;
  assign ram_adv_n     = 1'b0;
  assign ram_clk       = 1'b0;
  assign ram_cre       = 1'b0;
  assign ram_ub_n      = 1'b0;
  assign ram_lb_n      = 1'b0;

endmodule
